fetch_pc_unit: RTL

Parametrised instruction-fetch program counter for the single-cycle CPU. It generalises PC sequencing to configurable address and offset widths. It adds absolute jumps, call/return through a hardware return-address stack (RAS), a non-sticky stall and a sticky halt state. It sits at the front of the datapath: control decode drives its request inputs, and its `PC` output addresses instruction memory.

---
 rtl/fetch_pc_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch program counter: sequential/branch/jump sequencing, call/return
// through a circular return-address stack, single-cycle stall and sticky halt.
module fetch_pc_unit #(
    parameter int          PC_W       = 8,
    parameter int          OFF_W      = 5,
    parameter int          RAS_DEPTH  = 4,
    parameter int unsigned START_ADDR = 0,
    localparam int         CNT_W      = $clog2(RAS_DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Init,
    input  logic             Halt,
    input  logic             Stall,
    input  logic             Branch,
    input  logic [OFF_W-1:0] Target,
    input  logic             Jump,
    input  logic             Call,
    input  logic [PC_W-1:0]  JumpAddr,
    input  logic             Ret,
    output logic [PC_W-1:0]  PC,
    output logic             Halted,
    output logic [CNT_W-1:0] RasCount,
    output logic             RasOvf,
    output logic             RasUnf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);

    typedef enum logic {
        S_RUN,
        S_HALTED
    } state_e;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [PC_W-1:0]  ras_mem_q [RAS_DEPTH];
    logic             ras_we;
    logic [PC_W-1:0]  ras_wdata;

    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  pc_br;
    logic [PC_W-1:0]  off_ext;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    logic             ras_full;
    logic             ras_empty;

    // ptr_q is the next free slot; when full it also points at the oldest entry,
    // so a push in that state overwrites exactly the entry we want to drop.
    always_comb begin
        pc_inc    = pc_q + PC_W'(1);
        off_ext   = PC_W'($signed(Target));
        pc_br     = pc_q + off_ext;
        ptr_inc   = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        ptr_dec   = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - PTR_W'(1);
        ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
        ras_empty = (cnt_q == '0);
    end

    always_comb begin
        // NOTE: every variable gets a default before the priority chain, so no
        // path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        ras_we    = 1'b0;
        ras_wdata = pc_inc;

        if (Init) begin
            state_d = S_RUN;
            pc_d    = PC_W'(START_ADDR);
            cnt_d   = '0;
            ptr_d   = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (state_q == S_HALTED) begin
            state_d = S_HALTED;
        end else if (Halt) begin
            state_d = S_HALTED;
        end else if (Stall) begin
            pc_d = pc_q;
        end else if (Ret) begin
            if (!ras_empty) begin
                pc_d  = ras_mem_q[ptr_dec];
                ptr_d = ptr_dec;
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                pc_d  = pc_inc;
                unf_d = 1'b1;
            end
        end else if (Call) begin
            ras_we = 1'b1;
            ptr_d  = ptr_inc;
            pc_d   = JumpAddr;
            if (ras_full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (Jump) begin
            pc_d = JumpAddr;
        end else if (Branch) begin
            pc_d = pc_br;
        end else begin
            pc_d = pc_inc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_RUN;
            pc_q    <= PC_W'(START_ADDR);
            cnt_q   <= '0;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // NOTE: the stack storage has no reset; cnt_q alone decides which entries
    // are valid, so stale contents are never observed.
    always_ff @(posedge CLK) begin
        if (ras_we) begin
            ras_mem_q[ptr_q] <= ras_wdata;
        end
    end

    assign PC       = pc_q;
    assign Halted   = (state_q == S_HALTED);
    assign RasCount = cnt_q;
    assign RasOvf   = ovf_q;
    assign RasUnf   = unf_q;

endmodule
